// File: rtl/pwm_capture.sv
// pwm_capture: measures each complete cycle of an asynchronous PWM input.
// Reports, in prescaler ticks, the period (rise to rise) and the high time
// (rise to fall) with a one-cycle valid strobe. Measurements that saturate
// the period counter raise a timeout level instead.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   sig_in     asynchronous PWM input
//   period     ticks from one rising edge to the next (registered)
//   high_time  ticks from a rising edge to the following falling edge (registered)
//   valid      one-cycle pulse, period/high_time updated on the same edge
//   timeout    level, set on saturation, cleared by the next valid
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | wait for the synchronized input to read low
// S_ARMED | input low, waiting for the rise that opens the first window
// S_HIGH  | measuring, input high: count period and high time
// S_LOW   | measuring, input low: count period, capture on the next rise
module pwm_capture #(
   parameter int PRESCALE_TICKS = 600,
   parameter int CNT_WIDTH      = 16,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 valid,
   output logic                 timeout
);

   localparam int                 PW       = $clog2(PRESCALE_TICKS);
   localparam logic [PW-1:0]      PRE_LAST = PW'(PRESCALE_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_HIGH,
      S_LOW
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] prime_q, prime_d;
   logic                   s_d_q, s_d_d;
   logic [PW-1:0]          pre_q, pre_d;
   logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
   logic [CNT_WIDTH-1:0]   hi_cnt_q, hi_cnt_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
   logic                   valid_q, valid_d;
   logic                   timeout_q, timeout_d;

   logic s;
   logic rise;
   logic fall;
   logic tick;
   logic primed;
   logic sat_hit;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_WIDTH'(1) : v;
   endfunction

   assign s      = sync_q[SYNC_STAGES-1];
   assign rise   = s & ~s_d_q;
   assign fall   = ~s & s_d_q;
   assign tick   = (pre_q == PRE_LAST);
   // The synchronizer clears to 0, so a high input would look like a rise
   // until the chain has filled with real samples. IDLE only trusts s once
   // the chain is primed, which keeps a partial initial high out of results.
   assign primed  = prime_q[SYNC_STAGES-1];
   assign sat_hit = (per_cnt_q == CNT_MAX) && tick;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
      prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
      s_d_d   = s;
      pre_d   = tick ? '0 : pre_q + PW'(1);
   end

   always_comb begin
      state_d     = state_q;
      per_cnt_d   = per_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      timeout_d   = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (primed && !s) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            // A tick in the start-edge cycle belongs to no window.
            if (rise) begin
               per_cnt_d = '0;
               hi_cnt_d  = '0;
               state_d   = S_HIGH;
            end
         end
         S_HIGH: begin
            if (sat_hit) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               per_cnt_d = sat_inc(per_cnt_q, tick);
               hi_cnt_d  = sat_inc(hi_cnt_q, tick);
               if (fall) begin
                  state_d = S_LOW;
               end
            end
         end
         S_LOW: begin
            // A capturing rise takes priority over saturation in the same cycle.
            if (rise) begin
               period_d    = sat_inc(per_cnt_q, tick);
               high_time_d = hi_cnt_q;
               valid_d     = 1'b1;
               timeout_d   = 1'b0;
               per_cnt_d   = '0;
               hi_cnt_d    = '0;
               state_d     = S_HIGH;
            end else if (sat_hit) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               per_cnt_d = sat_inc(per_cnt_q, tick);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sync_q      <= '0;
         prime_q     <= '0;
         s_d_q       <= 1'b0;
         pre_q       <= '0;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         prime_q     <= prime_d;
         s_d_q       <= s_d_d;
         pre_q       <= pre_d;
         per_cnt_q   <= per_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (PRESCALE_TICKS=4, CNT_WIDTH=8, SYNC_STAGES=2).
// Each scenario is a per-cycle waveform for sig_in. A reference model works
// out, from edge times and tick arithmetic, which valid/timeout events must
// appear and when; a monitor pops and compares them as the DUT shows them.
module tb_pwm_capture;

   localparam int PT   = 4;
   localparam int CW   = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sig_in = 1'b0;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          timeout;

   pwm_capture #(
      .PRESCALE_TICKS(PT),
      .CNT_WIDTH     (CW),
      .SYNC_STAGES   (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sig_in   (sig_in),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   typedef struct {
      bit is_to;
      int cyc;
      int per;
      int hi;
   } exp_t;

   exp_t expq[$];
   bit   w[$];

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Synchronized input in cycle n is sig_in of cycle n-2 (chain clears to 0).
   function automatic int s_at(input int n);
      if (n >= 2 && (n - 2) < w.size()) return int'(w[n-2]);
      return 0;
   endfunction

   function automatic int find(input int n0, input int val);
      for (int n = n0; n < w.size(); n++)
         if (s_at(n) == val) return n;
      return -1;
   endfunction

   // Ticks fall on cycles c with c % PT == PT-1; count them in (a, b].
   function automatic int ticks(input int a, input int b);
      return (b + 1) / PT - (a + 1) / PT;
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic build_expect();
      int  len = w.size();
      int  last_p = 0, last_h = 0;
      bit  to_lvl = 0;
      bit  done = 0;
      int  n, start, f, r2, t1, tt;
      exp_t e;
      expq.delete();
      n = find(2, 0);
      while (!done) begin
         if (n < 0) begin done = 1; break; end
         start = find(n + 1, 1);
         if (start < 0) begin done = 1; break; end
         while (1) begin
            f  = find(start + 1, 0);
            r2 = (f < 0) ? -1 : find(f + 1, 1);
            t1 = start + 1;
            while ((t1 % PT) != PT - 1) t1++;
            tt = t1 + MAXC * PT;   // cycle of the tick that would exceed max
            if (r2 >= 0 && r2 <= tt) begin
               if (r2 > len - 2) begin done = 1; break; end
               e.is_to = 0;
               e.cyc   = r2 + 1;
               e.per   = min_i(ticks(start, r2), MAXC);
               e.hi    = min_i(ticks(start, f), MAXC);
               expq.push_back(e);
               last_p = e.per;
               last_h = e.hi;
               to_lvl = 0;
               start  = r2;
            end else begin
               if (tt > len - 2) begin done = 1; break; end
               if (!to_lvl) begin
                  e.is_to = 1;
                  e.cyc   = tt + 1;
                  e.per   = last_p;
                  e.hi    = last_h;
                  expq.push_back(e);
               end
               to_lvl = 1;
               n = find(tt + 1, 0);
               break;
            end
         end
      end
   endtask

   // ---------------- monitor ----------------
   int prev_p, prev_h;
   bit to_prev;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_p  = 0;
         prev_h  = 0;
         to_prev = 0;
      end else begin
         if (valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_valid_cycle", cyc, -1);
            end else begin
               e = expq.pop_front();
               chk("event_kind_valid", 0, int'(e.is_to));
               chk("valid_cycle", cyc, e.cyc);
               chk("period", int'(period), e.per);
               chk("high_time", int'(high_time), e.hi);
               chk("timeout_on_valid", int'(timeout), 0);
            end
         end else begin
            if (int'(period) != prev_p || int'(high_time) != prev_h)
               chk("outputs_held_without_valid", int'(period) * 256 + int'(high_time),
                   prev_p * 256 + prev_h);
            if (to_prev && !timeout)
               chk("timeout_cleared_without_valid", int'(timeout), 1);
         end
         if (timeout && !to_prev) begin
            if (expq.size() == 0) begin
               chk("unexpected_timeout_cycle", cyc, -1);
            end else begin
               e = expq.pop_front();
               chk("event_kind_timeout", 1, int'(e.is_to));
               chk("timeout_cycle", cyc, e.cyc);
               chk("period_held_on_timeout", int'(period), e.per);
               chk("high_time_held_on_timeout", int'(high_time), e.hi);
            end
         end
         prev_p  = int'(period);
         prev_h  = int'(high_time);
         to_prev = timeout;
      end
   end

   // ---------------- stimulus ----------------
   task automatic add(input bit v, input int len);
      for (int i = 0; i < len; i++) w.push_back(v);
   endtask

   task automatic pwm(input int reps);
      for (int i = 0; i < reps; i++) begin
         add(1, 12);
         add(0, 28);
      end
   endtask

   task automatic run_scenario(input string name);
      build_expect();
      reset  = 1'b1;
      sig_in = w[0];
      @(posedge clk);
      #1 reset = 1'b0;
      for (int n = 0; n < w.size(); n++) begin
         sig_in = w[n];
         @(posedge clk);
         #1;
      end
      chk({name, "_events_left"}, expq.size(), 0);
      // asynchronous reset mid-count: outputs clear with no clock edge
      reset = 1'b1;
      #1;
      chk({name, "_rst_period"}, int'(period), 0);
      chk({name, "_rst_high_time"}, int'(high_time), 0);
      chk({name, "_rst_valid"}, int'(valid), 0);
      chk({name, "_rst_timeout"}, int'(timeout), 0);
   endtask

   initial begin
      // steady 40/12 PWM across all prescaler phases
      for (int d = 0; d < 4; d++) begin
         w.delete();
         add(0, 5 + d);
         pwm(10);
         add(0, 10);
         run_scenario("steady");
      end

      // input high at reset release
      w.delete();
      add(1, 25);
      add(0, 20);
      pwm(6);
      add(0, 10);
      run_scenario("start_high");

      // timeout then recovery
      w.delete();
      add(0, 6);
      pwm(3);
      add(1, 1100);
      add(0, 28);
      pwm(5);
      add(0, 10);
      run_scenario("timeout");

      // boundary periods 1020 and 1024, ending held high into a timeout
      for (int d = 0; d < 4; d += 3) begin
         w.delete();
         add(0, 4 + d);
         add(1, 300); add(0, 720);
         add(1, 300); add(0, 720);
         add(1, 300); add(0, 724);
         add(1, 300); add(0, 724);
         add(1, 12);  add(0, 28);
         add(1, 1200);
         run_scenario("boundary");
      end

      // random high/low lengths with occasional very long lows
      for (int r = 0; r < 2; r++) begin
         w.delete();
         add(0, $urandom_range(3, 10));
         for (int i = 0; i < 40; i++) begin
            add(1, $urandom_range(1, 60));
            if ($urandom_range(0, 7) == 0) add(0, $urandom_range(900, 1100));
            else                           add(0, $urandom_range(1, 60));
         end
         add(0, 10);
         run_scenario("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
